// File: rtl/demux4way32_fifo_pkg.sv
// Shared datapath constants: 4-way select encoding and the default word width.
package demux4way32_fifo_pkg;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  localparam int unsigned WIDTH_DEF = 32;

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-clock synchronous FIFO for one demux channel; registered storage, mux read at the head.
module demux_chan_fifo
  import demux4way32_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  // Guarded here as well so the counter can never leave 0..DEPTH.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux4way32_fifo.sv
// Registered 1-to-4 demux with a FIFO per channel; a stalled consumer only blocks its own channel.
module demux4way32_fifo
  import demux4way32_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data_a,
  output logic [WIDTH-1:0] out_data_b,
  output logic [WIDTH-1:0] out_data_c,
  output logic [WIDTH-1:0] out_data_d,
  output logic [CW-1:0]    count_a,
  output logic [CW-1:0]    count_b,
  output logic [CW-1:0]    count_c,
  output logic [CW-1:0]    count_d
);

  logic [WIDTH-1:0] w_rdata [4];
  logic [CW-1:0]    w_count [4];
  logic [3:0]       w_full;
  logic [3:0]       w_empty;
  logic [3:0]       w_push;
  logic [3:0]       w_pop;

  // Depends only on in_sel and registered state, never on out_ready.
  assign in_ready  = !w_full[in_sel];
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_push = '0;
    if (in_valid && in_ready) begin
      case (in_sel)
        SEL_A:   w_push = 4'b0001;
        SEL_B:   w_push = 4'b0010;
        SEL_C:   w_push = 4'b0100;
        SEL_D:   w_push = 4'b1000;
        default: w_push = '0;
      endcase
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push[g]),
      .wdata (in_data),
      .pop   (w_pop[g]),
      .rdata (w_rdata[g]),
      .count (w_count[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  assign out_data_a = w_rdata[0];
  assign out_data_b = w_rdata[1];
  assign out_data_c = w_rdata[2];
  assign out_data_d = w_rdata[3];
  assign count_a    = w_count[0];
  assign count_b    = w_count[1];
  assign count_c    = w_count[2];
  assign count_d    = w_count[3];

endmodule

// File: tb/tb_demux4way32_fifo.sv
// Directed self-checking bench for demux4way32_fifo (WIDTH=32, DEPTH=4).
module tb_demux4way32_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data_a, out_data_b, out_data_c, out_data_d;
  logic [2:0]  count_a, count_b, count_c, count_d;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  demux4way32_fifo #(
    .WIDTH (32),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data_a (out_data_a),
    .out_data_b (out_data_b),
    .out_data_c (out_data_c),
    .out_data_d (out_data_d),
    .count_a    (count_a),
    .count_b    (count_b),
    .count_c    (count_c),
    .count_d    (count_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'b00;
    in_data   = 32'hDEADBEEF;
    out_ready = 4'b0000;
    step();
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b0000) $display("FAIL reset_out_valid got=%b exp=0000", out_valid); else n_pass++;
    n_checks++;
    if ({count_a, count_b, count_c, count_d} !== 12'h000)
      $display("FAIL reset_counts got=%0d %0d %0d %0d exp=0 0 0 0", count_a, count_b, count_c, count_d);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++;
    if ({out_data_a, out_data_b, out_data_c, out_data_d} !== 128'h0)
      $display("FAIL reset_out_data got=%h %h %h %h exp=0", out_data_a, out_data_b, out_data_c, out_data_d);
    else n_pass++;
    step();
    n_checks++;
    if (count_a !== 3'd0) $display("FAIL reset_no_store got=%0d exp=0", count_a); else n_pass++;
  endtask

  task automatic test_routing();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel = 2'b00; in_data = 32'h11111111; step();
    in_sel = 2'b01; in_data = 32'h22222222; step();
    in_sel = 2'b10; in_data = 32'h33333333; step();
    in_sel = 2'b11; in_data = 32'h44444444; step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b1111) $display("FAIL route_out_valid got=%b exp=1111", out_valid); else n_pass++;
    n_checks++;
    if ({out_data_a, out_data_b, out_data_c, out_data_d} !== {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444})
      $display("FAIL route_data got=%h %h %h %h exp=11111111 22222222 33333333 44444444",
               out_data_a, out_data_b, out_data_c, out_data_d);
    else n_pass++;
    n_checks++;
    if ({count_a, count_b, count_c, count_d} !== {3'd1, 3'd1, 3'd1, 3'd1})
      $display("FAIL route_counts got=%0d %0d %0d %0d exp=1 1 1 1", count_a, count_b, count_c, count_d);
    else n_pass++;
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    n_checks++;
    if (out_valid !== 4'b0000) $display("FAIL route_drain got=%b exp=0000", out_valid); else n_pass++;
  endtask

  task automatic test_full_and_simul();
    logic [31:0] exp_c [3];
    exp_c = '{32'hC0000002, 32'hC0000003, 32'hC0000004};
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'b10;
    for (int unsigned k = 0; k < 4; k++) begin
      in_data = 32'hC0000000 + k;
      step();
    end
    in_data = 32'hC0000004;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++;
    if (count_c !== 3'd4) $display("FAIL full_count_c got=%0d exp=4", count_c); else n_pass++;
    step();
    n_checks++;
    if (count_c !== 3'd4 || out_data_c !== 32'hC0000000)
      $display("FAIL full_stall got=%0d/%h exp=4/c0000000", count_c, out_data_c);
    else n_pass++;
    in_sel = 2'b00;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL full_other_ready got=%b exp=1", in_ready); else n_pass++;
    in_sel    = 2'b10;
    out_ready = 4'b0100;
    step();
    n_checks++;
    if (count_c !== 3'd3 || out_data_c !== 32'hC0000001)
      $display("FAIL simul_no_push got=%0d/%h exp=3/c0000001", count_c, out_data_c);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count_c !== 3'd3 || out_data_c !== 32'hC0000002)
      $display("FAIL simul_push_pop got=%0d/%h exp=3/c0000002", count_c, out_data_c);
    else n_pass++;
    for (int unsigned k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid[2] !== 1'b1 || out_data_c !== exp_c[k])
        $display("FAIL drain_c%0d got=%b/%h exp=1/%h", k, out_valid[2], out_data_c, exp_c[k]);
      else n_pass++;
      step();
    end
    out_ready = 4'b0000;
    n_checks++;
    if (count_c !== 3'd0) $display("FAIL drain_c_empty got=%0d exp=0", count_c); else n_pass++;
  endtask

  task automatic test_wrap_order();
    int unsigned tx = 0;
    int unsigned rx = 0;
    in_sel = 2'b01;
    for (int unsigned cyc = 0; cyc < 200 && rx < 10; cyc++) begin
      in_valid     = (tx < 10);
      in_data      = tx;
      out_ready[1] = (tx >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (count_b !== 3'(tx - rx)) $display("FAIL wrap_count_b got=%0d exp=%0d", count_b, tx - rx); else n_pass++;
      if (out_valid[1] && out_ready[1]) begin
        n_checks++;
        if (out_data_b !== rx) $display("FAIL wrap_order got=%h exp=%h", out_data_b, rx); else n_pass++;
        rx++;
      end
      if (in_valid && in_ready) tx++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    n_checks++;
    if (rx !== 10) $display("FAIL wrap_received got=%0d exp=10", rx); else n_pass++;
    n_checks++;
    if (count_b !== 3'd0) $display("FAIL wrap_count_end got=%0d exp=0", count_b); else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel = 2'b00; in_data = 32'hA0000000; step();
    in_sel = 2'b11; in_data = 32'hD0000000; step();
    in_sel = 2'b00; in_data = 32'hA0000001; step();
    in_sel = 2'b11; in_data = 32'hD0000001; step();
    in_valid = 1'b0;
    n_checks++;
    if (count_a !== 3'd2 || count_d !== 3'd2)
      $display("FAIL mid_prefill got=%0d %0d exp=2 2", count_a, count_d);
    else n_pass++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({count_a, count_b, count_c, count_d} !== 12'h000 || out_valid !== 4'b0000)
      $display("FAIL mid_reset got=%0d %0d %0d %0d/%b exp=0 0 0 0/0000",
               count_a, count_b, count_c, count_d, out_valid);
    else n_pass++;
    in_valid = 1'b1;
    in_sel   = 2'b11;
    in_data  = 32'h5555AAAA;
    #1;
    n_checks++;
    if (out_valid !== 4'b0000) $display("FAIL mid_no_bypass got=%b exp=0000", out_valid); else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b1000 || out_data_d !== 32'h5555AAAA || count_d !== 3'd1)
      $display("FAIL mid_push_d got=%b/%h/%0d exp=1000/5555aaaa/1", out_valid, out_data_d, count_d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_full_and_simul();
    test_wrap_order();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
